// File: rtl/bus_device_port.sv
// Device-side bus endpoint: a TX FIFO the bus drains via pndng/pop/D_pop and
// an address-filtered RX FIFO the bus fills via push/D_push. Overflow,
// underflow and misroute events are counted or flagged for the device.

// Circular-buffer FIFO with show-ahead read and reported drop/underflow events.
module bus_device_port_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_data,
  input  logic         i_rd,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic         o_full,
  output logic         o_ovf,
  output logic         o_udf
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_rd;
  logic          w_do_wr;

  // A read only happens when data exists; a write into a full FIFO is allowed
  // only when a read frees a slot in the same cycle.
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FULL_CNT);
  assign w_do_rd = i_rd && !o_empty;
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_ovf   = i_wr && !w_do_wr;
  assign o_udf   = i_rd && o_empty;
  assign o_data  = r_mem[r_rd_ptr];

  // Storage is cleared on reset so the show-ahead output reads 0 afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_do_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_do_wr) - (AW+1)'(w_do_rd);
    end
  end
endmodule

module bus_device_port #(
  parameter int          pckg_sz    = 16,
  parameter int          fifo_depth = 16,
  parameter logic [7:0]  id         = 8'd0,
  parameter logic [7:0]  broadcast  = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  output logic               rx_valid,
  output logic [pckg_sz-1:0] rx_data,
  input  logic               rx_rd,
  output logic [7:0]         tx_ovf_cnt,
  output logic [7:0]         rx_ovf_cnt,
  output logic [7:0]         udf_cnt,
  output logic               misroute
);
  logic       w_tx_empty;
  logic       w_tx_ovf;
  logic       w_tx_udf;
  logic       w_rx_empty;
  logic       w_rx_full;
  logic       w_rx_ovf;
  logic       w_rx_udf;
  logic [7:0] w_dest;
  logic       w_accept;
  logic       w_misroute_ev;
  logic [8:0] w_udf_sum;

  logic [7:0] r_tx_ovf_cnt;
  logic [7:0] r_rx_ovf_cnt;
  logic [7:0] r_udf_cnt;
  logic       r_misroute;

  assign w_dest        = D_push[pckg_sz-1 -: 8];
  assign w_accept      = (w_dest == id) || (w_dest == broadcast);
  assign w_misroute_ev = push && !w_accept;

  bus_device_port_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_tx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (tx_wr),
    .i_data  (tx_data),
    .i_rd    (pop),
    .o_data  (D_pop),
    .o_empty (w_tx_empty),
    .o_full  (tx_full),
    .o_ovf   (w_tx_ovf),
    .o_udf   (w_tx_udf)
  );

  // Misrouted pushes never reach the RX FIFO, so they cannot count as overflow.
  bus_device_port_fifo #(.W(pckg_sz), .DEPTH(fifo_depth)) u_rx_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (push && w_accept),
    .i_data  (D_push),
    .i_rd    (rx_rd),
    .o_data  (rx_data),
    .o_empty (w_rx_empty),
    .o_full  (w_rx_full),
    .o_ovf   (w_rx_ovf),
    .o_udf   (w_rx_udf)
  );

  assign pndng    = !w_tx_empty;
  assign rx_valid = !w_rx_empty;

  // Both underflow sources may fire together, so the sum is formed wide and clamped.
  assign w_udf_sum = {1'b0, r_udf_cnt} + 9'(w_tx_udf) + 9'(w_rx_udf);

  // Saturating event counters and the sticky misroute flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tx_ovf_cnt <= '0;
      r_rx_ovf_cnt <= '0;
      r_udf_cnt    <= '0;
      r_misroute   <= 1'b0;
    end else begin
      if (w_tx_ovf && (r_tx_ovf_cnt != 8'hFF)) r_tx_ovf_cnt <= r_tx_ovf_cnt + 8'd1;
      if (w_rx_ovf && (r_rx_ovf_cnt != 8'hFF)) r_rx_ovf_cnt <= r_rx_ovf_cnt + 8'd1;
      r_udf_cnt <= w_udf_sum[8] ? 8'hFF : w_udf_sum[7:0];
      if (w_misroute_ev) r_misroute <= 1'b1;
    end
  end

  assign tx_ovf_cnt = r_tx_ovf_cnt;
  assign rx_ovf_cnt = r_rx_ovf_cnt;
  assign udf_cnt    = r_udf_cnt;
  assign misroute   = r_misroute;

  // Full status of the RX FIFO is internal only; it is folded into overflow.
  logic w_unused;
  assign w_unused = w_rx_full;
endmodule

// File: tb/tb_bus_device_port.sv
// Directed bench for bus_device_port with id=3, 16-bit packets, depth 16.
module tb_bus_device_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        tx_wr, pop, push, rx_rd;
  logic [15:0] tx_data, D_push;
  logic        tx_full, pndng, rx_valid, misroute;
  logic [15:0] D_pop, rx_data;
  logic [7:0]  tx_ovf_cnt, rx_ovf_cnt, udf_cnt;

  int checks   = 0;
  int failures = 0;

  bus_device_port #(.pckg_sz(16), .fifo_depth(16), .id(8'd3), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset),
    .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_rd(rx_rd),
    .tx_ovf_cnt(tx_ovf_cnt), .rx_ovf_cnt(rx_ovf_cnt), .udf_cnt(udf_cnt),
    .misroute(misroute)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    tx_wr = 0; pop = 0; push = 0; rx_rd = 0;
  endtask

  initial begin
    idle();
    tx_data = '0; D_push = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_pndng", 32'(pndng), 0);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_D_pop", 32'(D_pop), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_tx_ovf", 32'(tx_ovf_cnt), 0);
    chk("rst_rx_ovf", 32'(rx_ovf_cnt), 0);
    chk("rst_udf", 32'(udf_cnt), 0);
    chk("rst_misroute", 32'(misroute), 0);

    // TX basic: 4 writes, 4 pops
    for (int i = 1; i <= 4; i++) begin
      tx_wr = 1; tx_data = 16'h0100 + 16'(i);
      tick();
      chk("tx_wr_pndng", 32'(pndng), 1);
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      chk("tx_pop_pndng", 32'(pndng), 1);
      chk("tx_pop_data", 32'(D_pop), 32'h0100 + 32'(i));
      pop = 1;
      tick();
    end
    idle();
    chk("tx_empty_after", 32'(pndng), 0);
    chk("tx_basic_udf", 32'(udf_cnt), 0);

    // RX address filtering
    push = 1;
    D_push = 16'h03AA; tick();
    D_push = 16'hFF55; tick();
    D_push = 16'h0711; tick();
    idle();
    chk("rx_valid", 32'(rx_valid), 1);
    chk("rx_data0", 32'(rx_data), 32'h03AA);
    chk("misroute_set", 32'(misroute), 1);
    chk("misroute_no_ovf", 32'(rx_ovf_cnt), 0);
    rx_rd = 1; tick(); idle();
    chk("rx_data1", 32'(rx_data), 32'hFF55);
    rx_rd = 1; tick(); idle();
    chk("rx_drained", 32'(rx_valid), 0);
    chk("misroute_sticky", 32'(misroute), 1);

    // TX overflow: 18 writes into depth 16
    for (int i = 0; i < 18; i++) begin
      tx_wr = 1; tx_data = 16'h1000 + 16'(i);
      tick();
      if (i == 14) chk("tx_not_full_15", 32'(tx_full), 0);
      if (i == 15) chk("tx_full_16", 32'(tx_full), 1);
    end
    idle();
    chk("tx_ovf_2", 32'(tx_ovf_cnt), 2);
    for (int i = 0; i < 16; i++) begin
      chk("tx_ovf_order", 32'(D_pop), 32'h1000 + 32'(i));
      pop = 1; tick();
    end
    idle();
    chk("tx_ovf_drained", 32'(pndng), 0);

    // TX simultaneous write and pop while full
    for (int i = 0; i < 16; i++) begin
      tx_wr = 1; tx_data = 16'h3000 + 16'(i); tick();
    end
    tx_wr = 1; pop = 1; tx_data = 16'h3100; tick(); idle();
    chk("tx_wrpop_full", 32'(tx_full), 1);
    chk("tx_wrpop_ovf", 32'(tx_ovf_cnt), 2);
    chk("tx_wrpop_head", 32'(D_pop), 32'h3001);
    for (int i = 1; i < 16; i++) begin
      chk("tx_wrpop_order", 32'(D_pop), 32'h3000 + 32'(i));
      pop = 1; tick();
    end
    idle();
    chk("tx_wrpop_tail", 32'(D_pop), 32'h3100);
    pop = 1; tick(); idle();
    chk("tx_wrpop_empty", 32'(pndng), 0);
    chk("tx_wrpop_udf", 32'(udf_cnt), 0);

    // RX overflow and simultaneous push/read while full
    for (int i = 0; i < 17; i++) begin
      push = 1; D_push = 16'h0300 + 16'(i); tick();
    end
    idle();
    chk("rx_ovf_1", 32'(rx_ovf_cnt), 1);
    push = 1; rx_rd = 1; D_push = 16'h03EE; tick(); idle();
    chk("rx_pushrd_ovf", 32'(rx_ovf_cnt), 1);
    chk("rx_pushrd_head", 32'(rx_data), 32'h0301);
    for (int i = 1; i < 16; i++) begin
      chk("rx_pushrd_order", 32'(rx_data), 32'h0300 + 32'(i));
      rx_rd = 1; tick();
    end
    idle();
    chk("rx_pushrd_tail", 32'(rx_data), 32'h03EE);
    rx_rd = 1; tick(); idle();
    chk("rx_pushrd_empty", 32'(rx_valid), 0);
    chk("rx_pushrd_udf", 32'(udf_cnt), 0);

    // Empty TX: write and pop together
    tx_wr = 1; pop = 1; tx_data = 16'h4444; tick(); idle();
    chk("tx_empty_wrpop_udf", 32'(udf_cnt), 1);
    chk("tx_empty_wrpop_pndng", 32'(pndng), 1);
    chk("tx_empty_wrpop_data", 32'(D_pop), 32'h4444);
    pop = 1; tick(); idle();
    chk("tx_empty_wrpop_gone", 32'(pndng), 0);

    // Both underflows in one cycle add 2
    pop = 1; rx_rd = 1; tick(); idle();
    chk("udf_double", 32'(udf_cnt), 3);

    // Underflow saturation
    for (int i = 0; i < 300; i++) begin
      pop = 1; tick();
    end
    idle();
    chk("udf_sat", 32'(udf_cnt), 32'hFF);
    pop = 1; rx_rd = 1; tick(); idle();
    chk("udf_sat_double", 32'(udf_cnt), 32'hFF);

    // Mid-cycle asynchronous reset with data in both FIFOs
    for (int i = 0; i < 5; i++) begin
      tx_wr = 1; tx_data = 16'h5000 + 16'(i);
      push = 1; D_push = 16'h0360 + 16'(i);
      tick();
    end
    idle();
    chk("pre_rst_pndng", 32'(pndng), 1);
    chk("pre_rst_rx_valid", 32'(rx_valid), 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_pndng", 32'(pndng), 0);
    chk("arst_rx_valid", 32'(rx_valid), 0);
    chk("arst_D_pop", 32'(D_pop), 0);
    chk("arst_rx_data", 32'(rx_data), 0);
    chk("arst_tx_ovf", 32'(tx_ovf_cnt), 0);
    chk("arst_rx_ovf", 32'(rx_ovf_cnt), 0);
    chk("arst_udf", 32'(udf_cnt), 0);
    chk("arst_misroute", 32'(misroute), 0);
    tx_wr = 1; pop = 1; rx_rd = 1; tx_data = 16'h6666;
    tick();
    idle();
    #2;
    reset = 1'b0;
    tick();
    chk("rst_strobe_ignored_pndng", 32'(pndng), 0);
    chk("rst_strobe_ignored_udf", 32'(udf_cnt), 0);
    tx_wr = 1; tx_data = 16'h5555;
    push = 1; D_push = 16'h0377;
    tick(); idle();
    chk("post_rst_pndng", 32'(pndng), 1);
    chk("post_rst_head", 32'(D_pop), 32'h5555);
    chk("post_rst_rx_head", 32'(rx_data), 32'h0377);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_device_port.md
Name: bus_device_port

Overview:
- Synthesizable device-side endpoint for the bus generator/arbiter interface; one instance per driver slot.
- TX path: the device writes packets into a transmit FIFO, which the bus drains through pndng/pop/D_pop.
- RX path: the bus delivers packets through push/D_push into a receive FIFO, which the device reads.
- RX packets are address-checked against the port's own ID and the broadcast ID; overflow, underflow and misroute events are counted or flagged.

Parameters:
- pckg_sz, 16, packet width in bits; the destination ID is the top 8 bits, pckg_sz-1 down to pckg_sz-8; must be at least 9.
- fifo_depth, 16, entries per FIFO; power of 2, at least 2.
- id, 0, 8-bit ID of this port.
- broadcast, 8'hFF, destination ID accepted by every port.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_wr  in  1  device write strobe into the TX FIFO.
- tx_data  in  pckg_sz  packet written on tx_wr.
- tx_full  out  1  TX FIFO holds fifo_depth entries.
- pndng  out  1  TX FIFO non-empty; bus-facing.
- D_pop  out  pckg_sz  head of the TX FIFO, show-ahead; bus-facing.
- pop  in  1  bus pop strobe; removes the TX head.
- push  in  1  bus push strobe into the RX FIFO.
- D_push  in  pckg_sz  packet delivered on push.
- rx_valid  out  1  RX FIFO non-empty.
- rx_data  out  pckg_sz  head of the RX FIFO, show-ahead.
- rx_rd  in  1  device read strobe; removes the RX head.
- tx_ovf_cnt  out  8  TX writes dropped because the FIFO was full; saturating.
- rx_ovf_cnt  out  8  RX pushes dropped because the FIFO was full; saturating.
- udf_cnt  out  8  pop while TX empty plus rx_rd while RX empty; saturating.
- misroute  out  1  sticky; set on a push whose destination is neither id nor broadcast.

Behaviour:
- Reset (async assert, sync deassert at clk edge): both FIFOs empty, pointers 0.
  - pndng=0, tx_full=0, rx_valid=0, D_pop=0, rx_data=0, all counters 0, misroute=0.
  - Asserting reset mid-operation discards all contents immediately; strobes during reset are ignored and not counted.
- FIFO structure: circular buffer with read/write pointers of log2(fifo_depth) bits, wrapping modulo fifo_depth.
  - Occupancy counter is log2(fifo_depth)+1 bits.
  - Empty means count 0; full means count equals fifo_depth.
- Read side is show-ahead: D_pop and rx_data are driven combinationally from the storage at the read pointer. They hold the last value or 0 when empty; consumers must ignore them when the FIFO is empty.
- TX write/pop:
  - tx_wr at edge N with room: word stored; pndng=1 from after edge N.
  - pop at edge N with pndng=1: head removed; the next head appears on D_pop after edge N.
- TX boundaries:
  - tx_wr while full and no pop: word dropped, tx_ovf_cnt+1.
  - tx_wr and pop together while full: both performed, count unchanged, no overflow.
  - pop while empty: ignored, udf_cnt+1.
  - tx_wr and pop together while empty: write stored, pop ignored and counted in udf_cnt, count becomes 1. There is no bypass.
- RX push acceptance: the destination field is D_push[pckg_sz-1:pckg_sz-8].
  - Destination equal to id or broadcast: push is accepted.
  - Otherwise: word dropped and misroute set. misroute is cleared only by reset. A misrouted push never counts as an overflow.
  - Accepted push with room: stored; rx_valid=1 after the edge.
  - Accepted push while full and no rx_rd: dropped, rx_ovf_cnt+1.
  - Accepted push with rx_rd together while full: both performed, no overflow.
  - rx_rd while empty: ignored, udf_cnt+1.
  - rx_rd and push together while empty: push stored, rx_rd counted as underflow.
- Counters saturate at 8'hFF and never wrap.
- udf_cnt increments by 2 when both underflow events occur in the same cycle; it still saturates.
- TX and RX paths are fully independent and may be active in the same cycle.

Test Plan:
- Reset, then write 0x0101..0x0104 into TX, then pop 4 times -> pndng high for 4 pops; D_pop sequence 0x0101,0x0102,0x0103,0x0104; pndng=0 after the last pop; udf_cnt=0.
- id=3: push 0x03AA, 0xFF55, 0x0711 -> rx_data sequence 0x03AA then 0xFF55; 0x0711 is dropped; misroute=1 and stays 1 after 2 reads.
- Write 18 words into TX with no pops (fifo_depth=16) -> tx_full=1 after the 16th; tx_ovf_cnt=2; 16 pops return the first 16 words in order.
- TX full, tx_wr and pop in the same cycle -> head removed, new word at the tail, tx_full stays 1, tx_ovf_cnt unchanged. Also run the RX equivalent.
- Empty TX, pop and tx_wr together -> udf_cnt=1, pndng=1 next cycle, D_pop equals the written word. Also apply 300 empty pops -> udf_cnt=0xFF.
- After 5 words in each FIFO, assert reset asynchronously mid-cycle -> pndng, rx_valid, counters and misroute go to 0 without waiting for a clk edge; the next write after deassert appears at the head.
